yutorina_bus_arbiter: RTL and testbench

YUTORINA_BUS_ARBITER -- requirements
Module: yutorina_bus_arbiter

---
 rtl/yutorina_bus_arbiter_pkg.sv | 22 ++
 rtl/yutorina_rr_pick.sv | 33 +++
 rtl/yutorina_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_yutorina_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared types and constants for the yutorina four-master bus arbiter.
// Master count and owner encoding are fixed here; the arbiter and picker import them.
package yutorina_bus_arbiter_pkg;

   localparam int unsigned NumM    = 4;
   localparam int unsigned OwnerW  = 2;
   localparam int unsigned TenureW = 8;

   localparam logic [OwnerW-1:0] ResetOwner     = 2'd0;
   // Last owner starts at the highest index so master 0 wins the first arbitration.
   localparam logic [OwnerW-1:0] ResetLastOwner = 2'd3;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } arb_state_e;

   function automatic logic [TenureW-1:0] tenure_sat_inc(input logic [TenureW-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/yutorina_rr_pick.sv
// Combinational 4-way round-robin picker: scans base+1, base+2, base+3, base+4 (mod 4)
// and returns the first requester as one-hot, index and a valid flag.
module yutorina_rr_pick
   import yutorina_bus_arbiter_pkg::*;
(
   input  logic [NumM-1:0]   req_i,
   input  logic [OwnerW-1:0] base_i,
   output logic [NumM-1:0]   grant_o,
   output logic [OwnerW-1:0] idx_o,
   output logic              valid_o
);

   logic [OwnerW-1:0] cand;
   logic              found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      // Offset NumM wraps back to base itself, so the base gets lowest priority.
      for (int unsigned i = 1; i <= NumM; i++) begin
         cand = base_i + OwnerW'(i);
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            idx_o          = cand;
            grant_o[cand]  = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin arbiter for four bus masters with a tenure limit, plus the shared-bus mux
// that forwards the granted master's strobe, direction, address and write data.
module yutorina_bus_arbiter
   import yutorina_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_M      = NumM,
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_TENURE = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_M-1:0]         m_req_i,
   output logic [NUM_M-1:0]         m_grant_o,
   input  logic [NUM_M-1:0]         m_as_i,
   input  logic [NUM_M-1:0]         m_rw_i,
   input  logic [NUM_M*ADDR_W-1:0]  m_addr_i,
   input  logic [NUM_M*DATA_W-1:0]  m_wr_data_i,
   output logic                     s_as_o,
   output logic                     s_rw_o,
   output logic [ADDR_W-1:0]        s_addr_o,
   output logic [DATA_W-1:0]        s_wr_data_o,
   output logic [OwnerW-1:0]        owner_o,
   output logic                     busy_o
);

   localparam bit TenureEn = (MAX_TENURE != 0);
   localparam logic [TenureW-1:0] TenureLimit =
      TenureW'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

   arb_state_e         state_q, state_d;
   logic [OwnerW-1:0]  owner_q, owner_d;
   logic [OwnerW-1:0]  last_owner_q, last_owner_d;
   logic [TenureW-1:0] tenure_q, tenure_d;
   logic [NUM_M-1:0]   grant_q, grant_d;

   logic [OwnerW-1:0]  pick_base;
   logic [NUM_M-1:0]   pick_grant;
   logic [OwnerW-1:0]  pick_idx;
   logic               pick_valid;
   logic               others_pending;
   logic               tenure_expired;

   assign pick_base = (state_q == StIdle) ? last_owner_q : owner_q;

   yutorina_rr_pick u_rr_pick (
      .req_i   (m_req_i),
      .base_i  (pick_base),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign others_pending = |(m_req_i & ~grant_q);
   assign tenure_expired = TenureEn && (tenure_q == TenureLimit);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      tenure_d     = tenure_q;
      grant_d      = grant_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d      = StBusy;
               owner_d      = pick_idx;
               last_owner_d = pick_idx;
               tenure_d     = '0;
               grant_d      = pick_grant;
            end
         end
         StBusy: begin
            if (!m_req_i[owner_q]) begin
               if (pick_valid) begin
                  owner_d      = pick_idx;
                  last_owner_d = pick_idx;
                  tenure_d     = '0;
                  grant_d      = pick_grant;
               end else begin
                  state_d  = StIdle;
                  tenure_d = '0;
                  grant_d  = '0;
               end
            end else if (tenure_expired) begin
               // Picker scans from owner+1, so the still-requesting owner ranks last.
               if (others_pending) begin
                  owner_d      = pick_idx;
                  last_owner_d = pick_idx;
                  tenure_d     = '0;
                  grant_d      = pick_grant;
               end
            end else begin
               tenure_d = tenure_sat_inc(tenure_q);
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         owner_q      <= ResetOwner;
         last_owner_q <= ResetLastOwner;
         tenure_q     <= '0;
         grant_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         tenure_q     <= tenure_d;
         grant_q      <= grant_d;
      end
   end

   assign m_grant_o = grant_q;
   assign owner_o   = owner_q;
   assign busy_o    = (state_q == StBusy);

   // Idle bus parks as a read of address 0 with the strobe low.
   always_comb begin
      s_as_o      = 1'b0;
      s_rw_o      = 1'b1;
      s_addr_o    = '0;
      s_wr_data_o = '0;
      if (state_q == StBusy) begin
         s_as_o      = m_as_i[owner_q];
         s_rw_o      = m_rw_i[owner_q];
         s_addr_o    = m_addr_i[owner_q*ADDR_W +: ADDR_W];
         s_wr_data_o = m_wr_data_i[owner_q*DATA_W +: DATA_W];
      end
   end

   a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(m_grant_o));
   a_busy_matches_grant: assert property (@(posedge clk_i) disable iff (rst_i)
      busy_o == (|m_grant_o));

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Scenario bench for yutorina_bus_arbiter: expected grants are queued as stimulus is
// driven and popped once the following clock edge has produced the DUT output.
module tb_yutorina_bus_arbiter;

   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;

   logic            clk;
   logic            rst;
   logic [3:0]      m_req;
   logic [3:0]      m_grant;
   logic [3:0]      m_as;
   logic [3:0]      m_rw;
   logic [4*AW-1:0] m_addr;
   logic [4*DW-1:0] m_wr_data;
   logic            s_as;
   logic            s_rw;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wr_data;
   logic [1:0]      owner;
   logic            busy;

   logic [AW-1:0]   addr_t [4];
   logic [DW-1:0]   wdat_t [4];

   logic [3:0]      exp_q [$];
   int              vectors;
   int              miscompares;

   yutorina_bus_arbiter #(
      .NUM_M      (4),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .MAX_TENURE (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .m_req_i     (m_req),
      .m_grant_o   (m_grant),
      .m_as_i      (m_as),
      .m_rw_i      (m_rw),
      .m_addr_i    (m_addr),
      .m_wr_data_i (m_wr_data),
      .s_as_o      (s_as),
      .s_rw_o      (s_rw),
      .s_addr_o    (s_addr),
      .s_wr_data_o (s_wr_data),
      .owner_o     (owner),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      m_addr    = '0;
      m_wr_data = '0;
      for (int i = 0; i < 4; i++) begin
         m_addr[i*AW +: AW]    = addr_t[i];
         m_wr_data[i*DW +: DW] = wdat_t[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      m_req = 4'b0000;
      m_as  = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      m_req = 4'b1111;
      tick();
      vectors++;
      if (m_grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_grant: got %b want 0000", m_grant);
      end
      vectors++;
      if (busy !== 1'b0 || owner !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_busy_owner: got busy=%b owner=%0d want busy=0 owner=0", busy, owner);
      end
      vectors++;
      if (s_as !== 1'b0 || s_rw !== 1'b1 || s_addr !== '0 || s_wr_data !== '0) begin
         miscompares++;
         $display("FAIL reset_bus_idle: got as=%b rw=%b addr=%h wd=%h want 0 1 0 0",
                  s_as, s_rw, s_addr, s_wr_data);
      end
      m_req = 4'b0000;
      rst   = 1'b0;
      tick();
   endtask

   task automatic test_single_req();
      logic [3:0] exp_g;
      do_reset();
      m_req = 4'b0100;
      #1;
      vectors++;
      if (m_grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_latency: got %b want 0000 before edge", m_grant);
      end
      exp_q.push_back(4'b0100);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g) begin
         miscompares++;
         $display("FAIL single_grant: got %b want %b", m_grant, exp_g);
      end
      vectors++;
      if (owner !== 2'd2 || busy !== 1'b1 || s_addr !== addr_t[2]) begin
         miscompares++;
         $display("FAIL single_owner_addr: got owner=%0d busy=%b addr=%h want 2 1 %h",
                  owner, busy, s_addr, addr_t[2]);
      end
      m_req = 4'b0000;
      exp_q.push_back(4'b0000);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_release: got grant=%b busy=%b want %b 0", m_grant, busy, exp_g);
      end
      vectors++;
      if (s_rw !== 1'b1 || s_addr !== '0 || s_wr_data !== '0) begin
         miscompares++;
         $display("FAIL idle_bus: got rw=%b addr=%h wd=%h want 1 0 0", s_rw, s_addr, s_wr_data);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] reqs [5];
      logic [3:0] exps [5];
      logic [3:0] exp_g;
      reqs = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      exps = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         m_req = reqs[k];
         exp_q.push_back(exps[k]);
         tick();
         exp_g = exp_q.pop_front();
         vectors++;
         if (m_grant !== exp_g || busy !== (k < 4)) begin
            miscompares++;
            $display("FAIL rr_step%0d: got grant=%b busy=%b want %b %b",
                     k, m_grant, busy, exp_g, (k < 4));
         end
      end
   endtask

   task automatic test_tenure();
      logic [3:0] exp_g;
      do_reset();
      m_req = 4'b0011;
      for (int k = 0; k < 12; k++) begin
         exp_q.push_back((k >= 4 && k < 8) ? 4'b0010 : 4'b0001);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_g = exp_q.pop_front();
         vectors++;
         if (m_grant !== exp_g) begin
            miscompares++;
            $display("FAIL tenure_cycle%0d: got %b want %b", k, m_grant, exp_g);
         end
      end
      m_req = 4'b0000;
      tick();
   endtask

   task automatic test_hold();
      logic [3:0] exp_g;
      int         bad;
      bad = 0;
      do_reset();
      m_req = 4'b0001;
      for (int k = 0; k < 100; k++) begin
         exp_q.push_back(4'b0001);
         tick();
         exp_g = exp_q.pop_front();
         vectors++;
         if (m_grant !== exp_g || busy !== 1'b1) begin
            miscompares++;
            bad++;
            if (bad < 4) begin
               $display("FAIL hold_cycle%0d: got grant=%b busy=%b want %b 1",
                        k, m_grant, busy, exp_g);
            end
         end
      end
      // Tenure already sits at its limit, so a newcomer takes over at the next edge.
      m_req = 4'b0101;
      exp_q.push_back(4'b0100);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g) begin
         miscompares++;
         $display("FAIL hold_then_rotate: got %b want %b", m_grant, exp_g);
      end
      m_req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_g;
      do_reset();
      m_req = 4'b1000;
      m_as  = 4'b1000;
      exp_q.push_back(4'b1000);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g || s_as !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pre_grant: got grant=%b as=%b want %b 1", m_grant, s_as, exp_g);
      end
      tick();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (m_grant !== 4'b0000 || s_as !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async_drop: got grant=%b as=%b busy=%b want 0000 0 0",
                  m_grant, s_as, busy);
      end
      tick();
      rst = 1'b0;
      exp_q.push_back(4'b1000);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g || owner !== 2'd3) begin
         miscompares++;
         $display("FAIL mid_regrant: got grant=%b owner=%0d want %b 3", m_grant, owner, exp_g);
      end
      m_req = 4'b0000;
      m_as  = 4'b0000;
      tick();
   endtask

   task automatic test_mux();
      logic [3:0]    exp_g;
      logic [AW-1:0] own_addr;
      do_reset();
      m_req = 4'b0010;
      m_as  = 4'b1111;
      m_rw  = 4'b0101;
      exp_q.push_back(4'b0010);
      tick();
      exp_g = exp_q.pop_front();
      vectors++;
      if (m_grant !== exp_g) begin
         miscompares++;
         $display("FAIL mux_grant: got %b want %b", m_grant, exp_g);
      end
      vectors++;
      if (s_addr !== addr_t[1] || s_wr_data !== wdat_t[1] || s_rw !== 1'b0 || s_as !== 1'b1) begin
         miscompares++;
         $display("FAIL mux_fields: got addr=%h wd=%h rw=%b as=%b want %h %h 0 1",
                  s_addr, s_wr_data, s_rw, s_as, addr_t[1], wdat_t[1]);
      end
      own_addr  = addr_t[1];
      addr_t[0] = 30'h0ABC_0000;
      addr_t[2] = 30'h0DEF_0000;
      addr_t[3] = 30'h0123_4567;
      #1;
      vectors++;
      if (s_addr !== own_addr) begin
         miscompares++;
         $display("FAIL mux_nonowner_addr: got %h want %h", s_addr, own_addr);
      end
      addr_t[1] = 30'h0555_AAAA;
      #1;
      vectors++;
      if (s_addr !== 30'h0555_AAAA) begin
         miscompares++;
         $display("FAIL mux_owner_track: got %h want 0555aaaa", s_addr);
      end
      m_as = 4'b1101;
      #1;
      vectors++;
      if (s_as !== 1'b0) begin
         miscompares++;
         $display("FAIL mux_nonowner_as: got %b want 0", s_as);
      end
      m_req = 4'b0000;
      m_as  = 4'b0000;
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      m_req       = 4'b0000;
      m_as        = 4'b0000;
      m_rw        = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         addr_t[i] = 30'((i + 1) * 32'h0111_1111);
         wdat_t[i] = 32'hDEAD_0000 | 32'(i);
      end
      test_reset();
      test_single_req();
      test_round_robin();
      test_tenure();
      test_hold();
      test_reset_mid();
      test_mux();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
